// File: rtl/dispatch_ctrl.sv
// Dispatch controller: 2-entry in-order buffer between decode and the
// ALU / memory issue queues, with in-flight branch budget and kill flush.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid, i_ctrl     decode handshake; ctrl = {pry[1:0], qtype[1:0], en}
//   i_data, i_brmask    payload and branch mask of the incoming micro-op
//   o_ready             buffer has room and branch budget not exhausted
//   o_alu_valid/i_alu_ready, o_mem_valid/i_mem_ready  head offer per queue
//   o_data, o_brmask, o_pry  head entry contents
//   i_br_done           one in-flight branch resolved
//   i_kill              flush buffer and branch count
//   o_br_cnt            in-flight branch count
module dispatch_ctrl #(
  parameter int WIDTH_BRM = 6,
  parameter int DATA_W    = 64,
  parameter int MAX_BR    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [4:0]           i_ctrl,
  input  logic [DATA_W-1:0]    i_data,
  input  logic [WIDTH_BRM-1:0] i_brmask,
  output logic                 o_ready,
  output logic                 o_alu_valid,
  input  logic                 i_alu_ready,
  output logic                 o_mem_valid,
  input  logic                 i_mem_ready,
  output logic [DATA_W-1:0]    o_data,
  output logic [WIDTH_BRM-1:0] o_brmask,
  output logic [1:0]           o_pry,
  input  logic                 i_br_done,
  input  logic                 i_kill,
  output logic [WIDTH_BRM-1:0] o_br_cnt
);

  localparam logic [1:0] QT_MEM = 2'b01;
  localparam logic [1:0] PRY_BR = 2'b11;
  localparam logic [WIDTH_BRM-1:0] MAX_C = WIDTH_BRM'(MAX_BR);

  logic [DATA_W-1:0]    data_q   [2];
  logic [WIDTH_BRM-1:0] brmask_q [2];
  logic [1:0]           pry_q    [2];
  logic [1:0]           qtype_q  [2];

  logic                 wptr;
  logic                 rptr;
  logic [1:0]           cnt;
  logic [1:0]           cnt_nxt;
  logic [WIDTH_BRM-1:0] br_cnt;
  logic [WIDTH_BRM-1:0] br_nxt;

  logic push;
  logic pop;
  logic br_inc;
  logic br_dec;
  logic head_mem;
  logic nonempty;

  assign o_ready  = (cnt != 2'd2) && (br_cnt < MAX_C);
  assign nonempty = (cnt != 2'd0);
  assign head_mem = (qtype_q[rptr] == QT_MEM);

  // Kill gates the offers combinationally so nothing leaves in a flush cycle.
  assign o_alu_valid = nonempty & ~head_mem & ~i_kill;
  assign o_mem_valid = nonempty &  head_mem & ~i_kill;

  assign o_data   = data_q[rptr];
  assign o_brmask = brmask_q[rptr];
  assign o_pry    = pry_q[rptr];
  assign o_br_cnt = br_cnt;

  assign push = i_valid & i_ctrl[0] & o_ready & ~i_kill;
  assign pop  = (o_alu_valid & i_alu_ready) | (o_mem_valid & i_mem_ready);

  assign br_inc = push & (i_ctrl[4:3] == PRY_BR);
  assign br_dec = i_br_done & (br_cnt != '0);

  always_comb begin
    cnt_nxt = cnt;
    unique case ({push, pop})
      2'b10:   cnt_nxt = cnt + 2'd1;
      2'b01:   cnt_nxt = cnt - 2'd1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_comb begin
    br_nxt = br_cnt;
    unique case ({br_inc, br_dec})
      2'b10:   br_nxt = br_cnt + 1'b1;
      2'b01:   br_nxt = br_cnt - 1'b1;
      default: br_nxt = br_cnt;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt    <= 2'd0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      br_cnt <= '0;
    end else if (i_kill) begin
      cnt    <= 2'd0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      br_cnt <= '0;
    end else begin
      cnt    <= cnt_nxt;
      br_cnt <= br_nxt;
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
    end
  end

  // Payload storage is cleared only by reset so the head reads 0 afterwards;
  // after a kill its contents are don't-care because both valids are low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q[0]   <= '0;
      data_q[1]   <= '0;
      brmask_q[0] <= '0;
      brmask_q[1] <= '0;
      pry_q[0]    <= '0;
      pry_q[1]    <= '0;
      qtype_q[0]  <= '0;
      qtype_q[1]  <= '0;
    end else if (push) begin
      data_q[wptr]   <= i_data;
      brmask_q[wptr] <= i_brmask;
      pry_q[wptr]    <= i_ctrl[4:3];
      qtype_q[wptr]  <= i_ctrl[2:1];
    end
  end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed testbench for dispatch_ctrl: reset, routing, back-pressure,
// masked drop, branch budget, kill and streaming wrap-around.
module tb_dispatch_ctrl;

  localparam int WB = 6;
  localparam int DW = 64;

  localparam logic [4:0] C_ALU  = 5'b00101;
  localparam logic [4:0] C_MEM  = 5'b00011;
  localparam logic [4:0] C_BR   = 5'b11101;
  localparam logic [4:0] C_MASK = 5'b00100;

  logic          clk;
  logic          rst;
  logic          valid;
  logic [4:0]    ctrl;
  logic [DW-1:0] data;
  logic [WB-1:0] brmask;
  logic          ready;
  logic          alu_valid;
  logic          alu_ready;
  logic          mem_valid;
  logic          mem_ready;
  logic [DW-1:0] odata;
  logic [WB-1:0] obrmask;
  logic [1:0]    opry;
  logic          br_done;
  logic          kill;
  logic [WB-1:0] br_cnt;

  int checks;
  int errors;

  dispatch_ctrl #(.WIDTH_BRM(WB), .DATA_W(DW), .MAX_BR(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (valid),
    .i_ctrl      (ctrl),
    .i_data      (data),
    .i_brmask    (brmask),
    .o_ready     (ready),
    .o_alu_valid (alu_valid),
    .i_alu_ready (alu_ready),
    .o_mem_valid (mem_valid),
    .i_mem_ready (mem_ready),
    .o_data      (odata),
    .o_brmask    (obrmask),
    .o_pry       (opry),
    .i_br_done   (br_done),
    .i_kill      (kill),
    .o_br_cnt    (br_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] c,
                       input logic [DW-1:0] d, input logic [WB-1:0] m);
    valid  = v;
    ctrl   = c;
    data   = d;
    brmask = m;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    br_done   = 1'b0;
    kill      = 1'b0;
    drive(1'b0, 5'b0, '0, '0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset then idle
    chk("rst_ready", ready, 1);
    chk("rst_alu_v", alu_valid, 0);
    chk("rst_mem_v", mem_valid, 0);
    chk("rst_brcnt", br_cnt, 0);
    chk("rst_data", odata, 0);
    chk("rst_pry", opry, 0);
    tick();
    tick();
    chk("idle_ready", ready, 1);
    chk("idle_alu_v", alu_valid, 0);
    chk("idle_mem_v", mem_valid, 0);

    // Routing and back-pressure
    drive(1'b1, C_ALU, 64'hA1, 6'h05);
    tick();
    chk("rt1_alu_v", alu_valid, 1);
    chk("rt1_ready", ready, 1);
    drive(1'b1, C_MEM, 64'hB2, 6'h0A);
    tick();
    drive(1'b0, 5'b0, '0, '0);
    chk("rt2_ready", ready, 0);
    chk("rt2_alu_v", alu_valid, 1);
    chk("rt2_mem_v", mem_valid, 0);
    chk("rt2_data", odata, 64'hA1);
    chk("rt2_brmask", obrmask, 6'h05);
    tick();
    chk("rt_hold_data", odata, 64'hA1);
    chk("rt_hold_alu_v", alu_valid, 1);
    mem_ready = 1'b1;
    #1;
    chk("rt_inorder_mem_v", mem_valid, 0);
    tick();
    chk("rt_blocked_data", odata, 64'hA1);
    mem_ready = 1'b0;
    alu_ready = 1'b1;
    tick();
    alu_ready = 1'b0;
    chk("rt3_mem_v", mem_valid, 1);
    chk("rt3_alu_v", alu_valid, 0);
    chk("rt3_ready", ready, 1);
    chk("rt3_data", odata, 64'hB2);
    chk("rt3_brmask", obrmask, 6'h0A);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("rt4_alu_v", alu_valid, 0);
    chk("rt4_mem_v", mem_valid, 0);

    // Masked drop
    drive(1'b1, C_MASK, 64'hCC, 6'h01);
    tick();
    drive(1'b0, 5'b0, '0, '0);
    chk("mask_alu_v", alu_valid, 0);
    chk("mask_mem_v", mem_valid, 0);
    chk("mask_ready", ready, 1);
    tick();
    chk("mask_alu_v2", alu_valid, 0);

    // Branch budget
    alu_ready = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, C_BR, 64'h100 + 64'(i), 6'(i));
      tick();
    end
    drive(1'b0, 5'b0, '0, '0);
    chk("br_cnt4", br_cnt, 4);
    chk("br_ready0", ready, 0);
    chk("br_pry", opry, 2'b11);
    chk("br_head", odata, 64'h103);
    br_done = 1'b1;
    tick();
    br_done = 1'b0;
    chk("br_cnt3", br_cnt, 3);
    chk("br_ready1", ready, 1);
    chk("br_empty", alu_valid, 0);
    drive(1'b1, C_BR, 64'h200, 6'h00);
    br_done = 1'b1;
    tick();
    br_done = 1'b0;
    drive(1'b0, 5'b0, '0, '0);
    chk("br_same_cyc", br_cnt, 3);
    chk("br_same_head", odata, 64'h200);
    br_done = 1'b1;
    tick();
    tick();
    tick();
    chk("br_drain", br_cnt, 0);
    tick();
    br_done = 1'b0;
    chk("br_floor", br_cnt, 0);
    alu_ready = 1'b0;
    mem_ready = 1'b0;

    // Kill mid-operation
    drive(1'b1, C_BR, 64'h300, 6'h11);
    tick();
    drive(1'b1, C_BR, 64'h301, 6'h12);
    tick();
    drive(1'b0, 5'b0, '0, '0);
    chk("kl_full_ready", ready, 0);
    chk("kl_brcnt2", br_cnt, 2);
    chk("kl_alu_v_pre", alu_valid, 1);
    kill      = 1'b1;
    alu_ready = 1'b1;
    drive(1'b1, C_ALU, 64'h3FF, 6'h00);
    #1;
    chk("kl_alu_v", alu_valid, 0);
    chk("kl_mem_v", mem_valid, 0);
    tick();
    kill = 1'b0;
    drive(1'b0, 5'b0, '0, '0);
    chk("kl_brcnt0", br_cnt, 0);
    chk("kl_ready", ready, 1);
    chk("kl_alu_v_post", alu_valid, 0);
    chk("kl_mem_v_post", mem_valid, 0);
    alu_ready = 1'b0;

    // Streaming and wrap-around
    alu_ready = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, (i % 2 == 0) ? C_ALU : C_MEM, 64'hD000 + 64'(i), 6'(i));
      tick();
      chk($sformatf("st%0d_alu_v", i), alu_valid, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("st%0d_mem_v", i), mem_valid, (i % 2 == 0) ? 0 : 1);
      chk($sformatf("st%0d_data", i), odata, 64'hD000 + 64'(i));
      chk($sformatf("st%0d_brmask", i), obrmask, 64'(i));
      chk($sformatf("st%0d_ready", i), ready, 1);
    end
    drive(1'b0, 5'b0, '0, '0);
    tick();
    chk("st_end_alu_v", alu_valid, 0);
    chk("st_end_mem_v", mem_valid, 0);
    alu_ready = 1'b0;
    mem_ready = 1'b0;

    // Reset overrides kill
    drive(1'b1, C_MEM, 64'hE0, 6'h00);
    tick();
    drive(1'b0, 5'b0, '0, '0);
    chk("rk_pre_mem_v", mem_valid, 1);
    rst  = 1'b1;
    kill = 1'b1;
    tick();
    rst  = 1'b0;
    kill = 1'b0;
    #1;
    chk("rk_mem_v", mem_valid, 0);
    chk("rk_data", odata, 0);
    chk("rk_ready", ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
